mochila_ext_bridge: RTL

Registered OBI bridge between the Mochila subsystem's external slave port and the host SoC bus. It consumes the request stream the subsystem drives on its external slave port and forwards it through a one-entry request slice. Responses return through a registered path. An outstanding-transaction counter throttles grants, and an optional timeout turns a hung host slave into an error response instead of a stalled core.

---
 rtl/mochila_ext_bridge.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mochila_ext_bridge.sv
// Registered OBI bridge from the Mochila external slave port to the host SoC bus.
// Optional hung-slave timeout: define MOCHILA_EXT_BRIDGE_TIMEOUT_EN.
package mochila_obi_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module mochila_ext_bridge
    import mochila_obi_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter logic [31:0] ERR_RDATA       = 32'hBADC_0DE5
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  obi_req_t  slv_req_i,
    output obi_resp_t slv_resp_o,
    output obi_req_t  mst_req_o,
    input  obi_resp_t mst_resp_i,
    output logic      busy_o,
    output logic      timeout_err_o,
    input  logic      err_clr_i
);

    logic        r_full;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [3:0]  r_issued;
    logic [3:0]  r_dn_out;

    logic [3:0]  w_drop;
    logic        w_timeout;
    logic        w_fwd;
    logic        w_gnt;
    logic        w_mst_hs;
    logic [4:0]  w_inflight;

    // Dropped transactions still occupy an outstanding slot until the host answers them.
    assign w_inflight = {1'b0, r_issued} + {1'b0, w_drop};
    assign w_gnt      = rst_ni && slv_req_i.req && (!r_full || mst_resp_i.gnt)
                        && (w_inflight < 5'(MAX_OUTSTANDING));
    assign w_mst_hs   = r_full && mst_resp_i.gnt;
    assign w_fwd      = mst_resp_i.rvalid && (w_drop == 4'd0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_full  <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if (w_gnt) begin
                r_full  <= 1'b1;
                r_we    <= slv_req_i.we;
                r_be    <= slv_req_i.be;
                r_addr  <= slv_req_i.addr;
                r_wdata <= slv_req_i.wdata;
            end else if (w_mst_hs) begin
                r_full  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_fwd || w_timeout;
            if (w_fwd) begin
                r_rdata <= mst_resp_i.rdata;
            end else if (w_timeout) begin
                r_rdata <= ERR_RDATA;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_issued <= '0;
            r_dn_out <= '0;
        end else begin
            r_issued <= r_issued + {3'b0, w_gnt} - {3'b0, r_rvalid};
            r_dn_out <= r_dn_out + {3'b0, w_mst_hs} - {3'b0, w_fwd} - {3'b0, w_timeout};
        end
    end

`ifdef MOCHILA_EXT_BRIDGE_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] r_timer;
    logic [3:0]    r_drop;
    logic          r_err;

    // Timer holds the number of waiting cycles already elapsed; expiry fires on the
    // TIMEOUT_CYCLES-th consecutive cycle with a transaction outstanding downstream.
    assign w_drop    = r_drop;
    assign w_timeout = (r_dn_out != 4'd0) && !mst_resp_i.rvalid
                       && (r_timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_timer <= '0;
            r_drop  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (mst_resp_i.rvalid || (r_dn_out == 4'd0) || w_timeout) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_timeout) begin
                r_drop <= r_drop + 4'd1;
            end else if (mst_resp_i.rvalid && (r_drop != 4'd0)) begin
                r_drop <= r_drop - 4'd1;
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end
        end
    end

    assign timeout_err_o = r_err;
`else
    logic w_unused_ok;

    assign w_drop        = '0;
    assign w_timeout     = 1'b0;
    assign timeout_err_o = 1'b0;
    assign w_unused_ok   = ^{err_clr_i, TIMEOUT_CYCLES};
`endif

    assign slv_resp_o = '{gnt: w_gnt, rvalid: r_rvalid, rdata: r_rdata};
    assign mst_req_o  = '{req: r_full, we: r_we, be: r_be, addr: r_addr, wdata: r_wdata};
    assign busy_o     = r_full || (r_issued != 4'd0) || (w_drop != 4'd0);

endmodule
